// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer: register map, CTRL bit positions and FSM states.
package pwm_pkg;

   localparam logic [1:0] AddrTarget = 2'd0;
   localparam logic [1:0] AddrStep   = 2'd1;
   localparam logic [1:0] AddrCtrl   = 2'd2;
   localparam logic [1:0] AddrDwell  = 2'd3;

   localparam int unsigned CtrlStartBit  = 0;
   localparam int unsigned CtrlAbortBit  = 1;
   localparam int unsigned CtrlIrqClrBit = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRamp,
      StDone
   } state_e;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides a pulse stream by a programmable dwell; emits step_en_o on every dwell-th tick.
module pwm_tick_prescaler #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             tick_i,
   input  logic [WIDTH-1:0] dwell_i,
   output logic             step_en_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] dwell_eff;

   always_comb begin
      // A dwell of zero behaves like one tick per step
      dwell_eff = (dwell_i == '0) ? WIDTH'(1) : dwell_i;
      cnt_inc   = cnt_q + WIDTH'(1);
      step_en_o = 1'b0;
      cnt_d     = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_inc >= dwell_eff) begin
            step_en_o = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Ramps DutyCycle toward a programmed target one step per dwell of PWM period ticks,
// then raises a sticky completion interrupt.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_DUTY  = 1000000,
   parameter int unsigned INIT_DUTY = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             period_tick,
   output logic [WIDTH-1:0] DutyCycle,
   output logic             busy,
   output logic             done_irq
);

   localparam logic [WIDTH-1:0] MaxDuty  = WIDTH'(MAX_DUTY);
   localparam logic [WIDTH-1:0] InitDuty = WIDTH'(INIT_DUTY);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] target_reg_q, target_reg_d;
   logic [WIDTH-1:0] step_reg_q, step_reg_d;
   logic [WIDTH-1:0] dwell_reg_q, dwell_reg_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] dwell_q, dwell_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             done_q, done_d;

   logic             ctrl_wr, start, abort, irq_clr;
   logic             going_up;
   logic [WIDTH-1:0] diff, next_duty;
   logic             presc_clear, presc_tick, step_en;

   assign ctrl_wr = wr_en && (wr_addr == AddrCtrl);
   assign abort   = ctrl_wr && wr_data[CtrlAbortBit];
   assign start   = ctrl_wr && wr_data[CtrlStartBit] && !wr_data[CtrlAbortBit];
   assign irq_clr = ctrl_wr && wr_data[CtrlIrqClrBit];

   // Compare first, then subtract the smaller from the larger: no wrap in either direction
   always_comb begin
      going_up = (tgt_q > duty_q);
      diff     = going_up ? (tgt_q - duty_q) : (duty_q - tgt_q);
      if (diff <= step_q) begin
         next_duty = tgt_q;
      end else begin
         next_duty = going_up ? (duty_q + step_q) : (duty_q - step_q);
      end
   end

   assign presc_clear = start || abort;
   assign presc_tick  = period_tick && (state_q == StRamp);

   pwm_tick_prescaler #(
      .WIDTH(WIDTH)
   ) u_prescaler (
      .clk_i    (Clk),
      .rst_ni   (Reset),
      .clear_i  (presc_clear),
      .tick_i   (presc_tick),
      .dwell_i  (dwell_q),
      .step_en_o(step_en)
   );

   always_comb begin
      target_reg_d = target_reg_q;
      step_reg_d   = step_reg_q;
      dwell_reg_d  = dwell_reg_q;
      if (wr_en) begin
         unique case (wr_addr)
            AddrTarget: target_reg_d = (wr_data > MaxDuty) ? MaxDuty : wr_data;
            AddrStep:   step_reg_d   = wr_data;
            AddrDwell:  dwell_reg_d  = wr_data;
            default:    ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      duty_d  = duty_q;
      done_d  = done_q;

      if (irq_clr) done_d = 1'b0;

      if (start) begin
         tgt_d   = target_reg_q;
         step_d  = step_reg_q;
         dwell_d = dwell_reg_q;
      end

      unique case (state_q)
         StIdle, StDone: begin
            // The DONE set is applied after irq_clear so it wins a same-cycle collision
            if (state_q == StDone) done_d = 1'b1;
            state_d = StIdle;
            if (start) begin
               if (target_reg_q == duty_q) begin
                  state_d = StDone;
               end else if (step_reg_q == '0) begin
                  duty_d  = target_reg_q;
                  state_d = StDone;
               end else begin
                  state_d = StRamp;
               end
            end
         end
         StRamp: begin
            if (abort) begin
               state_d = StIdle;
            end else if (start) begin
               if (target_reg_q == duty_q) begin
                  state_d = StDone;
               end else if (step_reg_q == '0) begin
                  duty_d  = target_reg_q;
                  state_d = StDone;
               end
            end else if (step_en) begin
               duty_d = next_duty;
               if (next_duty == tgt_q) state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= StIdle;
         target_reg_q <= '0;
         step_reg_q   <= WIDTH'(1);
         dwell_reg_q  <= WIDTH'(1);
         tgt_q        <= '0;
         step_q       <= WIDTH'(1);
         dwell_q      <= WIDTH'(1);
         duty_q       <= InitDuty;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_reg_q <= target_reg_d;
         step_reg_q   <= step_reg_d;
         dwell_reg_q  <= dwell_reg_d;
         tgt_q        <= tgt_d;
         step_q       <= step_d;
         dwell_q      <= dwell_d;
         duty_q       <= duty_d;
         done_q       <= done_d;
      end
   end

   assign DutyCycle = duty_q;
   // busy spans the one-cycle DONE state so it falls together with done_irq rising
   assign busy      = (state_q != StIdle);
   assign done_irq  = done_q;

endmodule
